// File: rtl/cart_bus_arbiter_if.sv
// Bundles the requester handshakes (core and debug) and the cartridge bus pins
// that cart_bus_arbiter owns.
// slave  : the arbiter side.
// master : the environment side (requesters, cartridge pins, halt control).
interface cart_bus_arbiter_if;
  // Requester-side control
  logic        halt;

  logic        core_req;
  logic        core_we;
  logic [15:0] core_addr;
  logic [7:0]  core_wdata;
  logic [7:0]  core_rdata;
  logic        core_ack;

  logic        dbg_req;
  logic        dbg_we;
  logic [15:0] dbg_addr;
  logic [7:0]  dbg_wdata;
  logic [7:0]  dbg_rdata;
  logic        dbg_ack;

  // Cartridge bus (strobes are active-high here; inverted at the pins)
  logic [15:0] bus_a;
  logic [7:0]  bus_dout;
  logic        bus_oe;
  logic [7:0]  bus_din;
  logic        bus_rd;
  logic        bus_wr;
  logic        bus_cs;
  logic        busy;

  modport slave (
    input  halt,
    input  core_req, core_we, core_addr, core_wdata,
    output core_rdata, core_ack,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_ack,
    output bus_a, bus_dout, bus_oe,
    input  bus_din,
    output bus_rd, bus_wr, bus_cs, busy
  );

  modport master (
    output halt,
    output core_req, core_we, core_addr, core_wdata,
    input  core_rdata, core_ack,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_ack,
    input  bus_a, bus_dout, bus_oe,
    output bus_din,
    input  bus_rd, bus_wr, bus_cs, busy
  );
endinterface

// File: rtl/cart_bus_arbiter.sv
// Cartridge bus arbiter: shares the external cartridge bus between the Game Boy
// core and the debug peek/poke engine. Each grant runs a fixed-timing
// SETUP/STROBE/HOLD cycle followed by a one-cycle DONE that pulses the
// requester's ack. Round-robin on ties; halt blocks core grants only.
module cart_bus_arbiter #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  cart_bus_arbiter_if.slave bus
);

  // Phase counter only needs to hold the longest phase length minus one.
  localparam int MAX_CYC = (SETUP_CYC > STROBE_CYC) ?
                           ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                           ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      addr_q, addr_d;
  logic             we_q, we_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             gnt_dbg_q, gnt_dbg_d;    // 1 = current transfer belongs to debug
  logic             last_dbg_q, last_dbg_d;  // 1 = debug was granted most recently
  logic [7:0]       cap_q, cap_d;            // byte sampled at the end of a read strobe
  logic [7:0]       core_rdata_q, core_rdata_d;
  logic [7:0]       dbg_rdata_q, dbg_rdata_d;

  // Arbitration inputs, only consulted in IDLE
  logic core_elig;
  logic dbg_elig;
  logic pick_dbg;

  // Bus-side outputs, decoded from the current state and latched request
  logic [15:0] bus_a_o;
  logic [7:0]  bus_dout_o;
  logic        bus_oe_o;
  logic        bus_rd_o;
  logic        bus_wr_o;
  logic        bus_cs_o;
  logic        core_ack_o;
  logic        dbg_ack_o;

  // Eligibility and round-robin tie-break: on a tie the side not granted last wins
  always_comb begin
    core_elig = bus.core_req & ~bus.halt;
    dbg_elig  = bus.dbg_req;
    pick_dbg  = dbg_elig & (~core_elig | ~last_dbg_q);
  end

  // State, phase counter, latched request and rdata registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      gnt_dbg_q    <= 1'b0;
      last_dbg_q   <= 1'b1;
      cap_q        <= '0;
      core_rdata_q <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      gnt_dbg_q    <= gnt_dbg_d;
      last_dbg_q   <= last_dbg_d;
      cap_q        <= cap_d;
      core_rdata_q <= core_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  // Next-state: grant in IDLE, time each phase with the down-counter
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    gnt_dbg_d    = gnt_dbg_q;
    last_dbg_d   = last_dbg_q;
    cap_d        = cap_q;
    core_rdata_d = core_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (core_elig || dbg_elig) begin
          // Requester signals are captured here and never looked at again
          gnt_dbg_d  = pick_dbg;
          last_dbg_d = pick_dbg;
          addr_d     = pick_dbg ? bus.dbg_addr  : bus.core_addr;
          we_d       = pick_dbg ? bus.dbg_we    : bus.core_we;
          wdata_d    = pick_dbg ? bus.dbg_wdata : bus.core_wdata;
          cnt_d      = SETUP_LOAD;
          state_d    = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (cnt_q == '0) begin
          cnt_d   = STROBE_LOAD;
          state_d = ST_STROBE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_STROBE: begin
        if (cnt_q == '0) begin
          // Read data is sampled on the edge that ends the strobe
          if (!we_q) begin
            cap_d = bus.bus_din;
          end
          cnt_d   = HOLD_LOAD;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_HOLD: begin
        if (cnt_q == '0) begin
          // Publish the captured byte to the owner so it is valid with ack
          if (!we_q) begin
            if (gnt_dbg_q) begin
              dbg_rdata_d = cap_q;
            end else begin
              core_rdata_d = cap_q;
            end
          end
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_DONE: begin
        // No arbitration here; IDLE always follows for at least one cycle
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bus drive and acks decoded from state so an async reset clears them at once
  always_comb begin
    bus_a_o    = '0;
    bus_dout_o = '0;
    bus_oe_o   = 1'b0;
    bus_rd_o   = 1'b0;
    bus_wr_o   = 1'b0;
    bus_cs_o   = 1'b0;
    core_ack_o = 1'b0;
    dbg_ack_o  = 1'b0;

    unique case (state_q)
      ST_SETUP, ST_HOLD: begin
        bus_a_o    = addr_q;
        bus_cs_o   = (addr_q[15:13] == 3'b101);
        bus_oe_o   = we_q;
        bus_dout_o = wdata_q;
      end

      ST_STROBE: begin
        bus_a_o    = addr_q;
        bus_cs_o   = (addr_q[15:13] == 3'b101);
        bus_oe_o   = we_q;
        bus_dout_o = wdata_q;
        bus_rd_o   = ~we_q;
        bus_wr_o   = we_q;
      end

      ST_DONE: begin
        core_ack_o = ~gnt_dbg_q;
        dbg_ack_o  = gnt_dbg_q;
      end

      default: begin
      end
    endcase
  end

  assign bus.bus_a      = bus_a_o;
  assign bus.bus_dout   = bus_dout_o;
  assign bus.bus_oe     = bus_oe_o;
  assign bus.bus_rd     = bus_rd_o;
  assign bus.bus_wr     = bus_wr_o;
  assign bus.bus_cs     = bus_cs_o;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.core_ack   = core_ack_o;
  assign bus.dbg_ack    = dbg_ack_o;
  assign bus.core_rdata = core_rdata_q;
  assign bus.dbg_rdata  = dbg_rdata_q;

endmodule
